// File: rtl/ram_loader.sv
// Write-side program loader for the CPU's RAM: accepts a byte stream and replays each
// byte as a MAR-load / RAM-write pair while holding the CPU halted. Option: RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LOAD_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_drive,
  output logic                  mar_in,
  output logic                  ram_in,
  output logic                  cpu_halt,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addr
`ifdef RAM_LOADER_CHECKSUM_EN
  ,
  output logic                  checksum_err
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LOAD_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SET_ADDR,
    WRITE,
    FINISH
`ifdef RAM_LOADER_CHECKSUM_EN
    ,
    WAIT_SUM
`endif
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] byte_q;
  logic                  last_addr;

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
`endif

  assign last_addr = (addr == LAST_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = WAIT_BYTE;
      WAIT_BYTE: if (in_valid) state_d = SET_ADDR;
      SET_ADDR:  state_d = WRITE;
      WRITE: begin
        if (last_addr) begin
`ifdef RAM_LOADER_CHECKSUM_EN
          state_d = WAIT_SUM;
`else
          state_d = FINISH;
`endif
        end else begin
          state_d = WAIT_BYTE;
        end
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      WAIT_SUM:  if (in_valid) state_d = FINISH;
`endif
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State-decoded bus and handshake outputs; stable for the whole cycle
  always_comb begin
    in_ready  = 1'b0;
    bus_drive = 1'b0;
    bus_out   = '0;
    mar_in    = 1'b0;
    ram_in    = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      WAIT_BYTE: in_ready = 1'b1;
      SET_ADDR: begin
        bus_drive = 1'b1;
        bus_out   = DATA_WIDTH'(addr);
        mar_in    = 1'b1;
      end
      WRITE: begin
        bus_drive = 1'b1;
        bus_out   = byte_q;
        ram_in    = 1'b1;
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      WAIT_SUM:  in_ready = 1'b1;
`endif
      FINISH:    done = 1'b1;
      default: ;
    endcase
  end

  // Registered datapath: address counter, captured byte, halt/busy flags
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      byte_q   <= '0;
      busy     <= 1'b0;
      cpu_halt <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      checksum_err <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            addr     <= '0;
            busy     <= 1'b1;
            cpu_halt <= 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            checksum_err <= 1'b0;
`endif
          end
        end
        WAIT_BYTE: begin
          if (in_valid) begin
            byte_q <= in_data;
`ifdef RAM_LOADER_CHECKSUM_EN
            sum_q  <= sum_q + in_data;
`endif
          end
        end
        WRITE: if (!last_addr) addr <= addr + ADDR_WIDTH'(1);
`ifdef RAM_LOADER_CHECKSUM_EN
        WAIT_SUM: if (in_valid) checksum_err <= (sum_q != in_data);
`endif
        FINISH: begin
          busy     <= 1'b0;
          cpu_halt <= 1'b0;
          addr     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Randomized scoreboard bench for ram_loader: expected RAM writes are queued at byte
// acceptance and checked by a monitor against observed MAR-load / RAM-write pairs.
module tb_ram_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 16;
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam int unsigned EXTRA = 1;
`else
  localparam int unsigned EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, bus_drive, mar_in, ram_in, cpu_halt, busy, done;
  logic [DW-1:0] bus_out;
  logic [AW-1:0] addr;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic          checksum_err;
`endif

  ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_DEPTH(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bus_out(bus_out), .bus_drive(bus_drive), .mar_in(mar_in),
    .ram_in(ram_in), .cpu_halt(cpu_halt), .busy(busy), .done(done), .addr(addr)
`ifdef RAM_LOADER_CHECKSUM_EN
    , .checksum_err(checksum_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  int            compared   = 0;
  int            mismatched = 0;
  int            cyc        = 0;
  int            done_cnt   = 0;
  int            wr_cnt     = 0;
  int            done_cyc   = 0;
  int            last_acc   = 0;
  logic [AW-1:0] mar_seen   = '0;
  logic [DW-1:0] tbl [3]    = '{8'h1F, 8'h30, 8'h2F};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard on every RAM write, watches bus ownership and done
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (mar_in || ram_in) check("strobe_drive", {30'd0, bus_drive, mar_in & ram_in}, 32'd2);
      else if (bus_drive) check("stray_drive", 32'(bus_drive), 32'd0);
      if (mar_in) begin
        check("mar_bus_hi", 32'(bus_out[DW-1:AW]), 32'd0);
        mar_seen = bus_out[AW-1:0];
      end
      if (ram_in) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(mar_seen), 32'(e.a));
          check("write_data", 32'(bus_out), 32'(e.d));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte after an optional idle gap; returns 1 cycle after the accepting edge
  task automatic send(input logic [DW-1:0] b, input logic [AW-1:0] exp_addr,
                      input bit push, input int gap);
    bit ok;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      check("halt_busy_addr", {26'd0, cpu_halt, busy, addr}, {26'd0, 2'b11, exp_addr});
      if (push) exp_q.push_back('{a: exp_addr, d: b});
      last_acc = cyc;
    end
    tick();
  endtask

  // One complete load; gap<0 means a random 0..3 idle cycles before each byte
  task automatic run_load(input int gap, input int mid_start_at, input bit timed);
    int            d0, first, g;
    logic [DW-1:0] b, sum, ext;
    bit            exp_err;
    d0  = done_cnt;
    sum = '0;
    first = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int idx = 0; idx < int'(N); idx++) begin
      b = (timed && idx < 3) ? tbl[idx] : DW'($urandom);
      g = (idx == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
      send(b, AW'(idx), 1'b1, g);
      if (idx == 0) first = last_acc;
      sum = sum + b;
      if (idx == mid_start_at) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    exp_err = 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
    exp_err = 1'(($urandom & 1) != 0);
    ext = exp_err ? (sum + DW'(1 + $urandom_range(0, 254))) : sum;
    send(ext, AW'(N - 1), 1'b0, 0);
`else
    ext = sum;
`endif
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    if (timed) check("load_cycles", 32'(done_cyc - first + 1), 32'(3 * N + 1 + EXTRA));
`ifdef RAM_LOADER_CHECKSUM_EN
    check("checksum_err", 32'(checksum_err), 32'(exp_err));
`endif
    @(negedge clk);
    check("released", {25'd0, cpu_halt, busy, done, addr}, 32'd0);
    repeat (5) @(negedge clk);
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("ext_unused", 32'(ext & 8'h00), 32'd0);
    tick();
  endtask

  initial begin
    int d0, w0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", {13'd0, in_ready, bus_out, bus_drive, mar_in, ram_in,
                            cpu_halt, busy, done, addr}, 32'd0);
    tick();
    rst = 1'b0;

    // Data offered with no load running must not be consumed
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (20) begin
      @(negedge clk);
      check("idle_data", {27'd0, in_ready, bus_drive, mar_in, ram_in, busy}, 32'd0);
    end
    tick();
    in_valid = 1'b0;

    run_load(0, -1, 1'b1);
    run_load(5, -1, 1'b0);
    run_load(0, 7, 1'b0);
    repeat (3) run_load(-1, -1, 1'b0);

    // Reset after the 4th write: no done, everything released
    d0 = done_cnt;
    w0 = wr_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int idx = 0; idx < 4; idx++) send(DW'($urandom), AW'(idx), 1'b1, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_cnt - w0 >= 4) break;
    end
    check("partial_writes", 32'(wr_cnt - w0), 32'd4);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midload_reset", {13'd0, in_ready, bus_out, bus_drive, mar_in, ram_in,
                            cpu_halt, busy, done, addr}, 32'd0);
    check("no_done_on_reset", 32'(done_cnt - d0), 32'd0);
    check("reset_queue", 32'(exp_q.size()), 32'd0);
    tick();
    rst = 1'b0;
    run_load(-1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
